// File: rtl/fix_bfp_norm.sv
// Block-floating-point normalizer: buffers a frame, finds the minimum redundant-sign-bit count, re-emits it shifted.
// Optional FIX_BFP_BYPASS_EN adds a per-frame bypass input that forces exp=0 with unshifted data.
module fix_bfp_norm #(
  parameter int WIDTH     = 16,
  parameter int FRAME_LEN = 8,
  parameter int EXP_WIDTH = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_WIDTH-1:0] out_exp,
  output logic                 out_last
`ifdef FIX_BFP_BYPASS_EN
  ,
  input  logic                 bypass
`endif
);

  localparam int                   CNT_W   = $clog2(FRAME_LEN);
  localparam logic [CNT_W-1:0]     LAST    = CNT_W'(FRAME_LEN - 1);
  localparam logic [EXP_WIDTH-1:0] RSB_MAX = EXP_WIDTH'(WIDTH - 1);

  typedef enum logic {FILL, DRAIN} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [EXP_WIDTH-1:0] min_rsb_q, min_rsb_d;
  logic [EXP_WIDTH-1:0] exp_q, exp_d;
  logic [WIDTH-1:0]     mem_q [FRAME_LEN];
  logic [EXP_WIDTH-1:0] in_rsb, min_rsb_new, shift;

  function automatic logic [EXP_WIDTH-1:0] rsb(input logic [WIDTH-1:0] x);
    logic                 run;
    logic [EXP_WIDTH-1:0] n;
    run = 1'b1;
    n   = '0;
    for (int i = WIDTH - 2; i >= 0; i--) begin
      if (run && (x[i] == x[WIDTH-1])) n = n + 1'b1;
      else                             run = 1'b0;
    end
    return n;
  endfunction

  assign in_rsb      = rsb(in_data);
  assign min_rsb_new = (in_rsb < min_rsb_q) ? in_rsb : min_rsb_q;

`ifdef FIX_BFP_BYPASS_EN
  logic bypass_q, bypass_d;
  assign shift = bypass_q ? '0 : exp_q;
`else
  assign shift = exp_q;
`endif

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    min_rsb_d = min_rsb_q;
    exp_d     = exp_q;
`ifdef FIX_BFP_BYPASS_EN
    bypass_d  = bypass_q;
`endif
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    out_exp   = '0;
    out_last  = 1'b0;
    case (state_q)
      FILL: begin
        in_ready = 1'b1;
        if (in_valid) begin
          count_d   = count_q + 1'b1;
          min_rsb_d = min_rsb_new;
`ifdef FIX_BFP_BYPASS_EN
          if (count_q == '0) bypass_d = bypass;
`endif
          // The final sample's own rsb must be folded into the frame exponent.
          if (count_q == LAST) begin
            exp_d   = min_rsb_new;
            count_d = '0;
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        out_valid = 1'b1;
        out_exp   = shift;
        out_data  = mem_q[count_q] << shift;
        out_last  = (count_q == LAST);
        if (out_ready) begin
          count_d = count_q + 1'b1;
          if (count_q == LAST) begin
            count_d   = '0;
            min_rsb_d = RSB_MAX;
            state_d   = FILL;
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FILL;
      count_q   <= '0;
      min_rsb_q <= RSB_MAX;
      exp_q     <= '0;
`ifdef FIX_BFP_BYPASS_EN
      bypass_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      min_rsb_q <= min_rsb_d;
      exp_q     <= exp_d;
`ifdef FIX_BFP_BYPASS_EN
      bypass_q  <= bypass_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if ((state_q == FILL) && in_valid) mem_q[count_q] <= in_data;
  end

endmodule

// File: tb/tb_fix_bfp_norm.sv
// Bench for fix_bfp_norm: directed vector table, reset corner sequences, and random frames vs. an arithmetic model.
module tb_fix_bfp_norm;
  localparam int W  = 16;
  localparam int L  = 8;
  localparam int EW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  in_data;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  out_data;
  logic          out_valid;
  logic          out_ready;
  logic [EW-1:0] out_exp;
  logic          out_last;
`ifdef FIX_BFP_BYPASS_EN
  logic          bypass = 1'b0;
`endif

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  fix_bfp_norm #(.WIDTH(W), .FRAME_LEN(L), .EXP_WIDTH(EW)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_exp(out_exp), .out_last(out_last)
`ifdef FIX_BFP_BYPASS_EN
    , .bypass(bypass)
`endif
  );

  typedef logic [L-1:0][W-1:0] frame_t;
  typedef struct packed {
    frame_t        din;
    logic [EW-1:0] exp;
    frame_t        dout;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    nvec++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Largest k such that x fits in a (W-k)-bit signed range.
  function automatic int model_rsb(input logic [W-1:0] x);
    int v;
    v = int'($signed(x));
    for (int k = W - 1; k >= 0; k--)
      if (v >= -(1 << (W - 1 - k)) && v < (1 << (W - 1 - k))) return k;
    return 0;
  endfunction

  task automatic send_sample(input logic [W-1:0] d);
    int t;
    t = 0;
    in_data  = d;
    in_valid = 1'b1;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      nerr++;
      $display("FAIL send_timeout: in_ready stuck at 0, required 1");
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input frame_t din);
    for (int i = 0; i < L; i++) send_sample(din[i]);
  endtask

  // mode 0: always ready, 1: random stalls, 2: five-cycle stall at sample 3
  task automatic drain(input frame_t dq, input logic [EW-1:0] e, input int mode);
    int   i, t, held;
    logic rdy;
    i = 0; t = 0; held = 0;
    while (i < L && t < 200) begin
      rdy = 1'b1;
      if (mode == 1) rdy = ($urandom_range(0, 2) != 0);
      if (mode == 2 && i == 3 && held < 5) begin
        rdy = 1'b0;
        held++;
      end
      out_ready = rdy;
      in_valid  = 1'b1;
      in_data   = W'($urandom);
      check("out_valid", 32'(out_valid), 32'd1);
      check("in_ready_drain", 32'(in_ready), 32'd0);
      check("out_data", 32'(out_data), 32'(dq[i]));
      check("out_exp", 32'(out_exp), 32'(e));
      check("out_last", 32'(out_last), 32'(i == L - 1));
      @(negedge clk);
      t++;
      if (rdy) i++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    if (t >= 200) begin
      nerr++;
      $display("FAIL drain_timeout: %0d of %0d samples drained", i, L);
    end
    check("post_out_valid", 32'(out_valid), 32'd0);
    check("post_in_ready", 32'(in_ready), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_exp", 32'(out_exp), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    frame_t        din, dq;
    logic [EW-1:0] e;
    logic signed [W-1:0] r;
    int            m;

    for (int i = 0; i < L; i++) begin
      vecs[0].din[i]  = W'(i + 1);
      vecs[0].dout[i] = W'((i + 1) << 11);
      vecs[1].din[i]  = '0;
      vecs[1].dout[i] = '0;
      vecs[2].din[i]  = (i == 0) ? 16'hFFFE : 16'h0001;
      vecs[2].dout[i] = (i == 0) ? 16'h8000 : 16'h4000;
      vecs[3].din[i]  = (i == 0) ? 16'h8000 : W'(i * 16'h0111);
      vecs[3].dout[i] = vecs[3].din[i];
      vecs[4].din[i]  = (i == 5) ? 16'h7FFF : W'(-i);
      vecs[4].dout[i] = vecs[4].din[i];
    end
    vecs[0].exp = 4'd11;
    vecs[1].exp = 4'd15;
    vecs[2].exp = 4'd14;
    vecs[3].exp = 4'd0;
    vecs[4].exp = 4'd0;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    @(negedge clk);
    do_reset();

    for (int v = 0; v < 5; v++) begin
      send_frame(vecs[v].din);
      drain(vecs[v].dout, vecs[v].exp, (v == 3) ? 2 : (v % 2));
    end

    // Reset after a partial fill discards it.
    for (int i = 0; i < 3; i++) send_sample(16'h7000);
    do_reset();
    send_frame(vecs[0].din);
    drain(vecs[0].dout, vecs[0].exp, 0);

    // Reset in the middle of draining.
    send_frame(vecs[2].din);
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    do_reset();
    send_frame(vecs[0].din);
    drain(vecs[0].dout, vecs[0].exp, 1);

    for (int f = 0; f < 25; f++) begin
      m = W - 1;
      for (int i = 0; i < L; i++) begin
        r = W'($urandom);
        din[i] = r >>> $urandom_range(0, W - 1);
        if (model_rsb(din[i]) < m) m = model_rsb(din[i]);
      end
      e = EW'(m);
      for (int i = 0; i < L; i++) dq[i] = din[i] << m;
      send_frame(din);
      drain(dq, e, f % 2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
